// File: rtl/core_lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller: access size
// encodings, controller states and the hazard stall-bus index it drives.
package core_lsu_ctrl_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    // Bit of the hazard controller's stall bus fed by lsu_stall_out (stall_wb).
    localparam int HZ_STALL_WB_BIT = 4;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_REQ  = 1'b1
    } lsu_state_e;

    // Size 2'b11 is not a legal encoding; it is handled like a word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            LSU_SIZE_B: mis = 1'b0;
            LSU_SIZE_H: mis = off[0];
            default:    mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_lsu_ctrl_align.sv
// Byte-lane logic for the LSU: store byte enables and data replication,
// load lane extraction and sign/zero extension. Purely combinational.
module lsu_align
    import core_lsu_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    st_size,
    input  logic [1:0]    st_off,
    input  logic [DW-1:0] st_wdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata_rep,
    input  logic [1:0]    ld_size,
    input  logic [1:0]    ld_off,
    input  logic          ld_uns,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] rdata_ext
);

    logic [DW-1:0] rdata_shift;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = st_wdata;
        case (st_size)
            LSU_SIZE_B: begin
                be        = 4'b0001 << st_off;
                wdata_rep = {4{st_wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                be        = st_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_shift = rdata >> {ld_off, 3'b000};
        rdata_ext   = rdata_shift;
        case (ld_size)
            LSU_SIZE_B: rdata_ext = {{(DW-8){~ld_uns & rdata_shift[7]}}, rdata_shift[7:0]};
            LSU_SIZE_H: rdata_ext = {{(DW-16){~ld_uns & rdata_shift[15]}}, rdata_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/core_lsu_ctrl.sv
// MEM-stage load/store controller: accepts a decoded access, runs the data
// bus req/ack handshake, stalls WB while it waits and returns load data.
//
// state    | meaning
// LSU_IDLE | no transfer in flight; an aligned access is latched here
// LSU_REQ  | dm_req_out high with latched fields until dm_ack_in
module core_lsu_ctrl
    import core_lsu_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_enb_in,
    input  logic          lsu_kill_in,
    input  logic          lsu_vld_in,
    input  logic          lsu_load_in,
    input  logic          lsu_store_in,
    input  logic [1:0]    lsu_size_in,
    input  logic          lsu_uns_in,
    input  logic [AW-1:0] lsu_addr_in,
    input  logic [DW-1:0] lsu_wdata_in,
    output logic          dm_req_out,
    output logic          dm_we_out,
    output logic [AW-1:0] dm_addr_out,
    output logic [3:0]    dm_be_out,
    output logic [DW-1:0] dm_wdata_out,
    input  logic          dm_ack_in,
    input  logic [DW-1:0] dm_rdata_in,
    output logic          lsu_stall_out,
    output logic [DW-1:0] lsu_rdata_out,
    output logic          lsu_rdata_vld_out,
    output logic          lsu_misalign_out
);

    lsu_state_e    state, state_nxt;
    logic          done_q;
    logic          kill_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          access, mis, accept, mis_det, ack_cyc;
    logic [3:0]    be_c;
    logic [DW-1:0] wdata_c, rdata_c;

    assign access = lsu_vld_in & (lsu_load_in | lsu_store_in) & ~lsu_kill_in & ~done_q;
    assign mis    = lsu_misaligned(lsu_size_in, lsu_addr_in[1:0]);

    lsu_align #(.DW(DW)) u_align (
        .st_size   (lsu_size_in),
        .st_off    (lsu_addr_in[1:0]),
        .st_wdata  (lsu_wdata_in),
        .be        (be_c),
        .wdata_rep (wdata_c),
        .ld_size   (size_q),
        .ld_off    (off_q),
        .ld_uns    (uns_q),
        .rdata     (dm_rdata_in),
        .rdata_ext (rdata_c)
    );

    always_comb begin
        state_nxt     = state;
        lsu_stall_out = 1'b0;
        accept        = 1'b0;
        mis_det       = 1'b0;
        ack_cyc       = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (access) begin
                    if (mis) begin
                        mis_det = 1'b1;
                    end else begin
                        accept        = 1'b1;
                        lsu_stall_out = 1'b1;
                        state_nxt     = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (dm_ack_in) begin
                    ack_cyc   = 1'b1;
                    state_nxt = LSU_IDLE;
                end else begin
                    lsu_stall_out = 1'b1;
                end
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    assign dm_req_out = (state == LSU_REQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= LSU_IDLE;
            done_q            <= 1'b0;
            kill_q            <= 1'b0;
            off_q             <= '0;
            size_q            <= '0;
            uns_q             <= 1'b0;
            dm_we_out         <= 1'b0;
            dm_addr_out       <= '0;
            dm_be_out         <= '0;
            dm_wdata_out      <= '0;
            lsu_rdata_out     <= '0;
            lsu_rdata_vld_out <= 1'b0;
            lsu_misalign_out  <= 1'b0;
        end else begin
            state            <= state_nxt;
            lsu_misalign_out <= mis_det;

            // Clearing wins so the instruction entering MEM on an ack cycle is not blocked.
            if (lsu_enb_in)
                done_q <= 1'b0;
            else if (ack_cyc || mis_det)
                done_q <= 1'b1;

            if (accept)
                kill_q <= 1'b0;
            else if (state == LSU_REQ && lsu_kill_in)
                kill_q <= 1'b1;

            if (accept) begin
                off_q        <= lsu_addr_in[1:0];
                size_q       <= lsu_size_in;
                uns_q        <= lsu_uns_in;
                dm_we_out    <= lsu_store_in;
                dm_addr_out  <= {lsu_addr_in[AW-1:2], 2'b00};
                dm_be_out    <= be_c;
                dm_wdata_out <= wdata_c;
            end

            lsu_rdata_vld_out <= ack_cyc & ~dm_we_out & ~(kill_q | lsu_kill_in);
            if (ack_cyc && !dm_we_out && !(kill_q || lsu_kill_in))
                lsu_rdata_out <= rdata_c;
        end
    end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Directed bench for core_lsu_ctrl: one task per scenario, hand-computed
// expectations, bus slave and pipeline enable driven by the bench.
module tb_core_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enb, kill, vld, load, store, uns, ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        dm_req, dm_we, stall, rvld, misal;
    logic [31:0] dm_addr, dm_wdata, rdata_out;
    logic [3:0]  dm_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lsu_enb_in        (enb),
        .lsu_kill_in       (kill),
        .lsu_vld_in        (vld),
        .lsu_load_in       (load),
        .lsu_store_in      (store),
        .lsu_size_in       (size),
        .lsu_uns_in        (uns),
        .lsu_addr_in       (addr),
        .lsu_wdata_in      (wdata),
        .dm_req_out        (dm_req),
        .dm_we_out         (dm_we),
        .dm_addr_out       (dm_addr),
        .dm_be_out         (dm_be),
        .dm_wdata_out      (dm_wdata),
        .dm_ack_in         (ack),
        .dm_rdata_in       (rdata),
        .lsu_stall_out     (stall),
        .lsu_rdata_out     (rdata_out),
        .lsu_rdata_vld_out (rvld),
        .lsu_misalign_out  (misal)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        vld = 0; load = 0; store = 0; kill = 0; ack = 0; enb = 0;
        size = 2'b00; uns = 0; addr = '0; wdata = '0; rdata = '0;
    endtask

    // Present one access, ack it after 'waits' request cycles; returns one cycle after the ack.
    task automatic run_access(input logic ld, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int waits, input logic enb_ack,
                              output int stalls, output int reqs, output logic [3:0] be_o,
                              output logic [31:0] addr_o, output logic [31:0] wdata_o,
                              output logic we_o, output logic timeout);
        stalls = 0; reqs = 0; timeout = 1;
        be_o = '0; addr_o = '0; wdata_o = '0; we_o = 0;
        vld = 1; load = ld; store = ~ld; size = sz; uns = u; addr = a; wdata = wd; rdata = rd;
        ack = 0; enb = 0; kill = 0;
        #1;
        if (stall) stalls++;
        cyc;
        for (int i = 0; i < 40; i++) begin
            if (dm_req) begin
                reqs++;
                be_o = dm_be; addr_o = dm_addr; wdata_o = dm_wdata; we_o = dm_we;
                ack = (reqs == waits + 1);
                enb = ack & enb_ack;
            end else begin
                ack = 0; enb = 0;
            end
            #1;
            if (stall) stalls++;
            if (ack) begin
                cyc;
                ack = 0; enb = 0; timeout = 0;
                break;
            end
            cyc;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        drive_idle();
        cyc; cyc; cyc;
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dm_req); end
        checks++; if ({dm_we, dm_be, dm_addr, dm_wdata} !== '0) begin errors++; $display("FAIL reset_bus got we=%b be=%h addr=%h wd=%h exp all 0", dm_we, dm_be, dm_addr, dm_wdata); end
        checks++; if ({stall, rvld, misal, rdata_out} !== '0) begin errors++; $display("FAIL reset_lsu got stall=%b vld=%b mis=%b rd=%h exp all 0", stall, rvld, misal, rdata_out); end
        rst_n = 1;
        cyc;
    endtask

    task automatic test_sw;
        int st, rq; logic [3:0] b; logic [31:0] a, w; logic we, to;
        run_access(0, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, st, rq, b, a, w, we, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL sw_timeout got=%b exp=0", to); end
        checks++; if (st !== 1) begin errors++; $display("FAIL sw_stall_cycles got=%0d exp=1", st); end
        checks++; if (rq !== 1) begin errors++; $display("FAIL sw_req_cycles got=%0d exp=1", rq); end
        checks++; if ({we, b, a, w} !== {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL sw_bus got we=%b be=%b addr=%h wd=%h exp 1 1111 00000100 deadbeef", we, b, a, w); end
        checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL sw_no_rvld got=%b exp=0", rvld); end
        drive_idle();
        cyc;
    endtask

    task automatic test_lb_waits;
        int st, rq; logic [3:0] b; logic [31:0] a, w; logic we, to;
        run_access(1, 2'b00, 0, 32'h203, 32'h0, 32'h80123456, 3, 1, st, rq, b, a, w, we, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL lb_timeout got=%b exp=0", to); end
        checks++; if (st !== 4) begin errors++; $display("FAIL lb_stall_cycles got=%0d exp=4", st); end
        checks++; if (rq !== 4) begin errors++; $display("FAIL lb_req_cycles got=%0d exp=4", rq); end
        checks++; if ({we, a} !== {1'b0, 32'h200}) begin errors++; $display("FAIL lb_bus got we=%b addr=%h exp 0 00000200", we, a); end
        checks++; if (rvld !== 1'b1) begin errors++; $display("FAIL lb_rvld got=%b exp=1", rvld); end
        checks++; if (rdata_out !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata_out); end
        drive_idle();
        cyc;
        checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL lb_rvld_pulse got=%b exp=0", rvld); end
        checks++; if (rdata_out !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata_hold got=%h exp=ffffff80", rdata_out); end
    endtask

    task automatic test_half;
        int st, rq; logic [3:0] b; logic [31:0] a, w; logic we, to;
        run_access(1, 2'b01, 1, 32'h202, 32'h0, 32'h80015678, 0, 1, st, rq, b, a, w, we, to);
        checks++; if (rdata_out !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got=%h exp=00008001", rdata_out); end
        run_access(0, 2'b01, 0, 32'h202, 32'hABCD1234, 32'h0, 0, 1, st, rq, b, a, w, we, to);
        checks++; if ({we, b, a, w} !== {1'b1, 4'b1100, 32'h200, 32'h12341234}) begin errors++; $display("FAIL sh_bus got we=%b be=%b addr=%h wd=%h exp 1 1100 00000200 12341234", we, b, a, w); end
        checks++; if (rdata_out !== 32'h00008001) begin errors++; $display("FAIL sh_rdata_hold got=%h exp=00008001", rdata_out); end
        drive_idle();
        cyc;
    endtask

    task automatic test_misalign;
        vld = 1; load = 1; size = 2'b10; addr = 32'h101; enb = 0;
        #1;
        checks++; if ({stall, dm_req} !== 2'b00) begin errors++; $display("FAIL mis_stall_req got stall=%b req=%b exp 0 0", stall, dm_req); end
        enb = 1;
        cyc;
        checks++; if ({misal, dm_req} !== 2'b10) begin errors++; $display("FAIL mis_pulse got mis=%b req=%b exp 1 0", misal, dm_req); end
        drive_idle();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall_after got=%b exp=0", stall); end
        cyc;
        checks++; if (misal !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got=%b exp=0", misal); end
    endtask

    task automatic test_back_to_back;
        int st, rq; logic [3:0] b; logic [31:0] a, w; logic we, to;
        run_access(0, 2'b00, 0, 32'h101, 32'h0000005A, 32'h0, 0, 1, st, rq, b, a, w, we, to);
        checks++; if ({we, b, a, w} !== {1'b1, 4'b0010, 32'h100, 32'h5A5A5A5A}) begin errors++; $display("FAIL sb_bus got we=%b be=%b addr=%h wd=%h exp 1 0010 00000100 5a5a5a5a", we, b, a, w); end
        checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL sb_no_rvld got=%b exp=0", rvld); end
        run_access(1, 2'b01, 0, 32'h200, 32'h0, 32'h12348001, 1, 1, st, rq, b, a, w, we, to);
        checks++; if ({st, rq} !== {32'd2, 32'd2}) begin errors++; $display("FAIL b2b_lh_cycles got stall=%0d req=%0d exp 2 2", st, rq); end
        checks++; if ({rvld, rdata_out} !== {1'b1, 32'hFFFF8001}) begin errors++; $display("FAIL b2b_lh_rdata got vld=%b rd=%h exp 1 ffff8001", rvld, rdata_out); end
        drive_idle();
        cyc;
    endtask

    task automatic test_done;
        int st, rq, extra; logic [3:0] b; logic [31:0] a, w; logic we, to;
        extra = 0;
        run_access(1, 2'b10, 0, 32'h300, 32'h0, 32'h11223344, 0, 0, st, rq, b, a, w, we, to);
        checks++; if ({rvld, rdata_out} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL done_rdata got vld=%b rd=%h exp 1 11223344", rvld, rdata_out); end
        for (int i = 0; i < 2; i++) begin
            #1;
            if (stall || dm_req) extra++;
            cyc;
            if (dm_req) extra++;
        end
        checks++; if ({rq, extra} !== {32'd1, 32'd0}) begin errors++; $display("FAIL done_reissue got reqs=%0d extra=%0d exp 1 0", rq, extra); end
        enb = 1;
        cyc;
        drive_idle();
        cyc;
    endtask

    task automatic test_kill;
        vld = 1; load = 1; size = 2'b10; addr = 32'h400; rdata = 32'hCAFEF00D; enb = 0;
        cyc;
        kill = 1; ack = 0;
        #1;
        checks++; if ({dm_req, stall} !== 2'b11) begin errors++; $display("FAIL kill_wait got req=%b stall=%b exp 1 1", dm_req, stall); end
        cyc;
        kill = 0; ack = 1; enb = 1;
        cyc;
        drive_idle();
        checks++; if ({rvld, dm_req} !== 2'b00) begin errors++; $display("FAIL kill_rvld got vld=%b req=%b exp 0 0", rvld, dm_req); end
        cyc;
        checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL kill_rvld_late got=%b exp=0", rvld); end
    endtask

    task automatic test_reset_mid;
        vld = 1; load = 1; size = 2'b10; addr = 32'h504; rdata = 32'h0; enb = 0;
        cyc;
        ack = 0;
        cyc;
        checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rstmid_waiting got=%b exp=1", dm_req); end
        rst_n = 0;
        drive_idle();
        cyc;
        checks++; if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== '0) begin errors++; $display("FAIL rstmid_bus got req=%b we=%b be=%h addr=%h wd=%h exp all 0", dm_req, dm_we, dm_be, dm_addr, dm_wdata); end
        checks++; if ({stall, rvld, misal, rdata_out} !== '0) begin errors++; $display("FAIL rstmid_lsu got stall=%b vld=%b mis=%b rd=%h exp all 0", stall, rvld, misal, rdata_out); end
        rst_n = 1;
        cyc;
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", dm_req); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_lb_waits();
        test_half();
        test_misalign();
        test_back_to_back();
        test_done();
        test_kill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
